// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core.
// Holds the default datapath widths, the opcode encodings and the reorder-buffer
// entry record used by rob_commit_unit.
package tomasulo_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = 3;
    localparam int DATA_W    = 8;
    localparam int REG_AW    = 4;
    localparam int OPC_W     = 4;

    localparam logic [OPC_W-1:0] OP_SUB   = 4'd0;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'd1;
    localparam logic [OPC_W-1:0] OP_MUL   = 4'd2;
    localparam logic [OPC_W-1:0] OP_DIV   = 4'd3;
    localparam logic [OPC_W-1:0] OP_STORE = 4'd4;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'd5;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] value;
        logic              occupied;
        logic              done;
    } rob_entry_t;

    // Stores retire without touching the register file.
    function automatic logic writes_reg(input logic [OPC_W-1:0] op);
        return op != OP_STORE;
    endfunction

endpackage

// File: rtl/rob_wrap_ptr.sv
// Modulo-DEPTH pointer for the reorder buffer (used for head and tail).
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset, clears the pointer to 0
//   inc   - advance the pointer by one, wrapping DEPTH-1 -> 0
//   ptr   - current pointer value
module rob_wrap_ptr #(
    parameter int DEPTH = 8,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order retirement for the Tomasulo core.
// Issue allocates entries at the tail, the CDB completes them by tag, and the
// head entry retires once done, producing a one-cycle register-file write and
// rename-tag release.
// Ports:
//   clk, rst_n                   - clock; synchronous active-low reset
//   alloc_valid/ready/opcode/dest - allocation request from issue
//   alloc_tag                    - tag granted to the allocation (tail pointer)
//   wb_valid/wb_tag/wb_value     - CDB result writeback
//   commit_valid/we/reg/value/tag - registered retire outputs
//   count, empty                 - occupancy
//   wb_err                       - sticky flag: writeback hit a free or done entry
// Optional feature macro ROB_OPERAND_READ_EN adds rd0/rd1 source-lookup ports
// (tag in, ready/value out) with a same-cycle bypass from the CDB.
import tomasulo_pkg::*;

module rob_commit_unit #(
    parameter int ROB_DEPTH = tomasulo_pkg::ROB_DEPTH,
    parameter int TAG_W     = tomasulo_pkg::TAG_W,
    parameter int DATA_W    = tomasulo_pkg::DATA_W,
    parameter int REG_AW    = tomasulo_pkg::REG_AW,
    parameter int OPC_W     = tomasulo_pkg::OPC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [OPC_W-1:0]  alloc_opcode,
    input  logic [REG_AW-1:0] alloc_dest,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_value,
`ifdef ROB_OPERAND_READ_EN
    input  logic [TAG_W-1:0]  rd0_tag,
    output logic              rd0_ready,
    output logic [DATA_W-1:0] rd0_value,
    input  logic [TAG_W-1:0]  rd1_tag,
    output logic              rd1_ready,
    output logic [DATA_W-1:0] rd1_value,
`endif
    output logic              commit_valid,
    output logic              commit_we,
    output logic [REG_AW-1:0] commit_reg,
    output logic [DATA_W-1:0] commit_value,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [TAG_W:0]    count,
    output logic              empty,
    output logic              wb_err
);

    rob_entry_t rob [ROB_DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic             alloc_fire;
    logic             commit_fire;

    // Full/empty come from count so head==tail is never ambiguous.
    assign alloc_ready = (count != (TAG_W + 1)'(ROB_DEPTH));
    assign empty       = (count == '0);
    assign alloc_tag   = tail;
    assign alloc_fire  = alloc_valid && alloc_ready;
    // Uses registered done only: a writeback landing this edge retires next edge.
    assign commit_fire = rob[head].occupied && rob[head].done;

    rob_wrap_ptr #(.DEPTH(ROB_DEPTH), .W(TAG_W)) u_head_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (commit_fire),
        .ptr   (head)
    );

    rob_wrap_ptr #(.DEPTH(ROB_DEPTH), .W(TAG_W)) u_tail_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (alloc_fire),
        .ptr   (tail)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count        <= '0;
            commit_valid <= 1'b0;
            commit_we    <= 1'b0;
            commit_reg   <= '0;
            commit_value <= '0;
            commit_tag   <= '0;
            wb_err       <= 1'b0;
            // Only status bits are cleared; payload fields are don't-care when free.
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob[i].occupied <= 1'b0;
                rob[i].done     <= 1'b0;
            end
        end else begin
            commit_valid <= commit_fire;
            if (commit_fire) begin
                commit_we          <= writes_reg(rob[head].opcode);
                commit_reg         <= rob[head].dest;
                commit_value       <= rob[head].value;
                commit_tag         <= head;
                rob[head].occupied <= 1'b0;
                rob[head].done     <= 1'b0;
            end

            // A retiring head is already done, so a same-cycle writeback to it
            // is rejected as an error and never collides with the free above.
            if (wb_valid) begin
                if (rob[wb_tag].occupied && !rob[wb_tag].done) begin
                    rob[wb_tag].value <= wb_value;
                    rob[wb_tag].done  <= 1'b1;
                end else begin
                    wb_err <= 1'b1;
                end
            end

            // Tail is free whenever alloc_fire is set, so it cannot equal a
            // retiring head (that would require a full buffer).
            if (alloc_fire) begin
                rob[tail].opcode   <= alloc_opcode;
                rob[tail].dest     <= alloc_dest;
                rob[tail].occupied <= 1'b1;
                rob[tail].done     <= 1'b0;
            end

            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ROB_OPERAND_READ_EN
    // Source lookup for issue: a completed entry, or one completing on the CDB
    // this very cycle, is ready; the CDB value is forwarded in the latter case.
    always_comb begin
        rd0_ready = rob[rd0_tag].done || (wb_valid && (wb_tag == rd0_tag));
        rd0_value = rob[rd0_tag].done ? rob[rd0_tag].value : wb_value;
        rd1_ready = rob[rd1_tag].done || (wb_valid && (wb_tag == rd1_tag));
        rd1_value = rob[rd1_tag].done ? rob[rd1_tag].value : wb_value;
    end
`else
    // Without the lookup ports the buffer is write-only from issue.
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
module tb_rob_commit_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [3:0] alloc_opcode;
    logic [3:0] alloc_dest;
    logic [2:0] alloc_tag;
    logic       wb_valid;
    logic [2:0] wb_tag;
    logic [7:0] wb_value;
    logic       commit_valid;
    logic       commit_we;
    logic [3:0] commit_reg;
    logic [7:0] commit_value;
    logic [2:0] commit_tag;
    logic [3:0] count;
    logic       empty;
    logic       wb_err;
`ifdef ROB_OPERAND_READ_EN
    logic [2:0] rd0_tag, rd1_tag;
    logic       rd0_ready, rd1_ready;
    logic [7:0] rd0_value, rd1_value;
`endif

    int vecs = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] rg;
        logic [7:0] val;
        logic [2:0] tag;
        logic       we;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    rob_commit_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_opcode (alloc_opcode),
        .alloc_dest   (alloc_dest),
        .alloc_tag    (alloc_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_value     (wb_value),
`ifdef ROB_OPERAND_READ_EN
        .rd0_tag      (rd0_tag),
        .rd0_ready    (rd0_ready),
        .rd0_value    (rd0_value),
        .rd1_tag      (rd1_tag),
        .rd1_ready    (rd1_ready),
        .rd1_value    (rd1_value),
`endif
        .commit_valid (commit_valid),
        .commit_we    (commit_we),
        .commit_reg   (commit_reg),
        .commit_value (commit_value),
        .commit_tag   (commit_tag),
        .count        (count),
        .empty        (empty),
        .wb_err       (wb_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every retire pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (commit_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("commit_spurious", 32'(commit_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("commit_tag",   32'(commit_tag),   32'(e.tag));
                check("commit_reg",   32'(commit_reg),   32'(e.rg));
                check("commit_value", 32'(commit_value), 32'(e.val));
                check("commit_we",    32'(commit_we),    32'(e.we));
            end
        end
    end

    task automatic do_alloc(input logic [3:0] op, input logic [3:0] dest,
                            input logic [2:0] etag, input logic [7:0] eval, input bit push);
        exp_t e;
        alloc_valid  = 1'b1;
        alloc_opcode = op;
        alloc_dest   = dest;
        #1;
        check("alloc_tag", 32'(alloc_tag), 32'(etag));
        if (push) begin
            e.rg = dest; e.val = eval; e.tag = etag; e.we = (op != 4'd4);
            q.push_back(e);
        end
        @(posedge clk); #1;
        alloc_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [2:0] tag, input logic [7:0] val);
        wb_valid = 1'b1;
        wb_tag   = tag;
        wb_value = val;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; alloc_valid = 1'b0; alloc_opcode = '0; alloc_dest = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_value = '0;
`ifdef ROB_OPERAND_READ_EN
        rd0_tag = '0; rd1_tag = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_empty",       32'(empty),       32'd1);
        check("rst_count",       32'(count),       32'd0);
        check("rst_alloc_tag",   32'(alloc_tag),   32'd0);
        check("rst_commit_valid",32'(commit_valid),32'd0);
        check("rst_commit_we",   32'(commit_we),   32'd0);
        check("rst_commit_reg",  32'(commit_reg),  32'd0);
        check("rst_commit_value",32'(commit_value),32'd0);
        check("rst_commit_tag",  32'(commit_tag),  32'd0);
        check("rst_wb_err",      32'(wb_err),      32'd0);
        rst_n = 1'b1;

        // Single ADD round trip; retire visible the cycle after edge E+1.
        do_alloc(4'd1, 4'd3, 3'd0, 8'h2A, 1'b1);
        do_wb(3'd0, 8'h2A);
        @(negedge clk);
        check("t1_no_bypass_cv", 32'(commit_valid), 32'd0);
        check("t1_count_before", 32'(count), 32'd1);
        @(negedge clk);
        check("t1_cv", 32'(commit_valid), 32'd1);
        check("t1_count_after", 32'(count), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);
        wait_drain("t1_drain");

        // Out-of-order completion, in-order back-to-back retirement.
        do_reset();
        do_alloc(4'd1, 4'd1, 3'd0, 8'd33, 1'b1);
        do_alloc(4'd0, 4'd2, 3'd1, 8'd22, 1'b1);
        do_alloc(4'd2, 4'd3, 3'd2, 8'd11, 1'b1);
        do_wb(3'd2, 8'd11);
        do_wb(3'd1, 8'd22);
        do_wb(3'd0, 8'd33);
        @(negedge clk);
        check("t2_cv0", 32'(commit_valid), 32'd0);
        @(negedge clk);
        check("t2_cv1", 32'(commit_valid), 32'd1);
        @(negedge clk);
        check("t2_cv2", 32'(commit_valid), 32'd1);
        @(negedge clk);
        check("t2_cv3", 32'(commit_valid), 32'd1);
        @(negedge clk);
        check("t2_cv4", 32'(commit_valid), 32'd0);
        check("t2_empty", 32'(empty), 32'd1);
        wait_drain("t2_drain");

        // Fill, blocked 9th alloc, free one slot, wrap to tag 0.
        do_reset();
        for (int i = 0; i < 8; i++)
            do_alloc(4'd1, 4'(i), 3'(i), 8'h10 + 8'(i), 1'b1);
        @(negedge clk);
        check("t3_full_count", 32'(count), 32'd8);
        check("t3_full_ready", 32'(alloc_ready), 32'd0);
        check("t3_full_tag", 32'(alloc_tag), 32'd0);
        alloc_valid = 1'b1; alloc_opcode = 4'd2; alloc_dest = 4'd15;
        @(posedge clk); #1;
        alloc_valid = 1'b0;
        @(negedge clk);
        check("t3_ninth_count", 32'(count), 32'd8);
        do_wb(3'd0, 8'h10);
        @(negedge clk);
        check("t3_wb_count", 32'(count), 32'd8);
        check("t3_wb_ready", 32'(alloc_ready), 32'd0);
        @(negedge clk);
        check("t3_freed_count", 32'(count), 32'd7);
        check("t3_freed_ready", 32'(alloc_ready), 32'd1);
        do_alloc(4'd1, 4'd9, 3'd0, 8'h55, 1'b1);
        for (int i = 1; i < 8; i++)
            do_wb(3'(i), 8'h10 + 8'(i));
        do_wb(3'd0, 8'h55);
        wait_drain("t3_drain");
        check("t3_empty", 32'(empty), 32'd1);

        // Store retires without a register write.
        do_reset();
        do_alloc(4'd4, 4'd7, 3'd0, 8'h99, 1'b1);
        do_wb(3'd0, 8'h99);
        wait_drain("t4_drain");

        // Writeback to a free entry, then reset with entries in flight.
        do_wb(3'd5, 8'h01);
        @(negedge clk);
        check("t5_wb_err", 32'(wb_err), 32'd1);
        check("t5_err_count", 32'(count), 32'd0);
        check("t5_err_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 4; i++)
            do_alloc(4'd1, 4'(i), 3'(i + 1), 8'h00, 1'b0);
        @(negedge clk);
        check("t5_count4", 32'(count), 32'd4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_rst_cv", 32'(commit_valid), 32'd0);
        check("t5_rst_count", 32'(count), 32'd0);
        check("t5_rst_empty", 32'(empty), 32'd1);
        check("t5_rst_wb_err", 32'(wb_err), 32'd0);
        check("t5_rst_ready", 32'(alloc_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_post_cv", 32'(commit_valid), 32'd0);

`ifdef ROB_OPERAND_READ_EN
        // Operand lookup with same-cycle CDB bypass.
        do_reset();
        do_alloc(4'd1, 4'd2, 3'd0, 8'h44, 1'b1);
        do_alloc(4'd1, 4'd5, 3'd1, 8'd7, 1'b1);
        rd0_tag = 3'd1; rd1_tag = 3'd0;
        wb_valid = 1'b1; wb_tag = 3'd1; wb_value = 8'd7;
        #1;
        check("rd0_ready", 32'(rd0_ready), 32'd1);
        check("rd0_value", 32'(rd0_value), 32'd7);
        check("rd1_ready", 32'(rd1_ready), 32'd0);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        #1;
        check("rd0_ready_stored", 32'(rd0_ready), 32'd1);
        check("rd0_value_stored", 32'(rd0_value), 32'd7);
        do_wb(3'd0, 8'h44);
        wait_drain("t6_drain");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
